// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
//   state_e  : arbiter FSM states (idle / word transfer in progress)
//   pick_t   : result of a round-robin search (found flag + winner index)
//   clog2    : ceil(log2(n)), never below 1 so counters always have a bit
//   nbeats   : number of output beats per requester word
//   rr_pick  : reference round-robin search over up to MaxReq requesters
package bus_arb_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StXfer = 1'b1
  } state_e;

  localparam int unsigned MaxReq = 32;
  localparam int unsigned MaxIdW = 5;

  typedef struct packed {
    logic              found;
    logic [MaxIdW-1:0] idx;
  } pick_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned nbeats(input int unsigned wordw, input int unsigned dataw);
    return wordw / dataw;
  endfunction

  // Scan last+1, last+2, ... (mod nreq) and return the first requester found.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] req, input int unsigned last,
                                    input int unsigned nreq);
    pick_t       p;
    int unsigned idx;
    p = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      if (k <= nreq && !p.found) begin
        idx = last + k;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx]) begin
          p.found = 1'b1;
          p.idx   = idx[MaxIdW-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector (NREQ bits)
//   last  : index of the most recently served requester
//   found : at least one request bit is set
//   sel   : winner, first set bit scanning last+1, last+2, ... (mod NREQ)
// Rotates the request vector so last+1 sits at bit 0, priority-encodes the
// lowest set bit, then rotates the offset back into a requester index.
module bus_arb_rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            found,
  output logic [IDW-1:0]  sel
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  pick_t             ref_pick;
  int unsigned       start;
  int unsigned       off;
  int unsigned       pos;

  always_comb begin
    start = 32'(last) + 1;
    if (start >= NREQ) start = 0;
    dbl   = {req, req};
    rot   = dbl[start +: NREQ];
    found = |rot;
    off   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = unsigned'(k);
    end
    pos = start + off;
    if (pos >= NREQ) pos = pos - NREQ;
    sel = IDW'(pos);

    // Cross-check the rotate/encode path against the straightforward scan.
    ref_pick = rr_pick(MaxReq'(req), 32'(last), NREQ);
    assert (ref_pick.found == found && (!found || ref_pick.idx == MaxIdW'(sel)));
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-way round-robin arbiter and word serialiser for the shared byte-wide bus.
// Each requester offers one WORDW-bit word (address + command byte); the
// granted word is latched and streamed LSB-beat first over valid/ready.
// Ports:
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   req         : per-requester level request
//   data_in     : requester i word at [i*WORDW +: WORDW]
//   grant       : one-hot, held for the whole transfer
//   grant_id    : index of the granted requester
//   done        : one-cycle pulse after the last beat of a word is accepted
//   busy        : transfer in progress
//   data_out    : current beat, data_valid qualifies it, data_ready accepts it
// Optional feature: define BUS_ARB_BURST_EN to let a requester that still holds
// req keep the grant for up to MAXBURST words before round-robin resumes.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned ADDRW    = 24,
  parameter int unsigned DATAW    = 8,
`ifdef BUS_ARB_BURST_EN
  parameter int unsigned MAXBURST = 4,
`endif
  localparam int unsigned WORDW   = ADDRW + 8,
  localparam int unsigned IDW     = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WORDW-1:0] data_in,
  output logic [NREQ-1:0]       grant,
  output logic [IDW-1:0]        grant_id,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [DATAW-1:0]      data_out,
  output logic                  data_valid,
  input  logic                  data_ready
);

  localparam int unsigned NBEATS = nbeats(WORDW, DATAW);
  localparam int unsigned CNTW   = clog2(NBEATS);

  state_e            state_q, state_d;
  logic [WORDW-1:0]  word_q, word_d;
  logic [CNTW-1:0]   beat_q, beat_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]    gid_q, gid_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [NREQ-1:0]   done_q, done_d;
`ifdef BUS_ARB_BURST_EN
  localparam int unsigned BCW = clog2(MAXBURST);
  logic [BCW-1:0]    burst_q, burst_d;
  logic              keep_grant;
`endif

  logic [NREQ-1:0]   pick_req;
  logic [IDW-1:0]    pick_last;
  logic              pick_found;
  logic [IDW-1:0]    pick_sel;
  logic [NREQ-1:0]   sel_oh;

  // While a word is finishing, the current owner is masked and the search
  // starts just after it, so the next winner can follow with no bubble.
  always_comb begin
    if (state_q == StXfer) begin
      pick_req  = req & ~grant_q;
      pick_last = gid_q;
    end else begin
      pick_req  = req;
      pick_last = last_q;
    end
    sel_oh           = '0;
    sel_oh[pick_sel] = 1'b1;
  end

  bus_arb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (pick_req),
    .last  (pick_last),
    .found (pick_found),
    .sel   (pick_sel)
  );

`ifdef BUS_ARB_BURST_EN
  assign keep_grant = req[gid_q] && (burst_q < BCW'(MAXBURST - 1));
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    beat_d  = beat_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    last_d  = last_q;
    done_d  = '0;
`ifdef BUS_ARB_BURST_EN
    burst_d = burst_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StXfer;
          word_d  = data_in[pick_sel*WORDW +: WORDW];
          beat_d  = '0;
          grant_d = sel_oh;
          gid_d   = pick_sel;
`ifdef BUS_ARB_BURST_EN
          burst_d = '0;
`endif
        end
      end
      StXfer: begin
        if (data_ready) begin
          if (beat_q != CNTW'(NBEATS - 1)) begin
            word_d = word_q >> DATAW;
            beat_d = beat_q + CNTW'(1);
          end else begin
            done_d = grant_q;
            last_d = gid_q;
            beat_d = '0;
`ifdef BUS_ARB_BURST_EN
            if (keep_grant) begin
              word_d  = data_in[gid_q*WORDW +: WORDW];
              burst_d = burst_q + BCW'(1);
            end else
`endif
            if (pick_found) begin
              word_d  = data_in[pick_sel*WORDW +: WORDW];
              grant_d = sel_oh;
              gid_d   = pick_sel;
`ifdef BUS_ARB_BURST_EN
              burst_d = '0;
`endif
            end else begin
              state_d = StIdle;
              grant_d = '0;
              word_d  = '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      beat_q  <= '0;
      grant_q <= '0;
      gid_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      done_q  <= '0;
`ifdef BUS_ARB_BURST_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef BUS_ARB_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign grant_id   = gid_q;
  assign done       = done_q;
  assign busy       = (state_q == StXfer);
  assign data_valid = (state_q == StXfer);
  assign data_out   = word_q[DATAW-1:0];

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr.
// A 2-requester instance runs a vector table (reset, single word, ready
// stall, reset mid-transfer) and a held-request sequence; a 4-requester
// instance checks round-robin order when one requester drops out.
// With BUS_ARB_BURST_EN defined the 2-requester instance uses MAXBURST=2.
module tb_bus_arbiter_rr;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] data_in;
  logic [1:0]  grant;
  logic [0:0]  grant_id;
  logic [1:0]  done;
  logic        busy;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;

  logic         rst4;
  logic [3:0]   req4;
  logic [127:0] data_in4;
  logic [3:0]   grant4;
  logic [1:0]   grant_id4;
  logic [3:0]   done4;
  logic         busy4;
  logic [7:0]   data_out4;
  logic         data_valid4;
  logic         data_ready4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] words [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BUS_ARB_BURST_EN
  bus_arbiter_rr #(.NREQ(2), .ADDRW(24), .DATAW(8), .MAXBURST(2)) u_dut2 (
`else
  bus_arbiter_rr #(.NREQ(2), .ADDRW(24), .DATAW(8)) u_dut2 (
`endif
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .grant      (grant),
    .grant_id   (grant_id),
    .done       (done),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready)
  );

`ifdef BUS_ARB_BURST_EN
  bus_arbiter_rr #(.NREQ(4), .ADDRW(24), .DATAW(8), .MAXBURST(1)) u_dut4 (
`else
  bus_arbiter_rr #(.NREQ(4), .ADDRW(24), .DATAW(8)) u_dut4 (
`endif
    .clk        (clk),
    .rst        (rst4),
    .req        (req4),
    .data_in    (data_in4),
    .grant      (grant4),
    .grant_id   (grant_id4),
    .done       (done4),
    .busy       (busy4),
    .data_out   (data_out4),
    .data_valid (data_valid4),
    .data_ready (data_ready4)
  );

  typedef struct packed {
    logic       rst;
    logic [1:0] req;
    logic       rdy;
    logic [1:0] e_grant;
    logic       e_gid;
    logic [1:0] e_done;
    logic       e_act;   // busy and data_valid
    logic [7:0] e_data;  // checked when active or in reset
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic rd,
                              input logic [1:0] g, input logic id, input logic [1:0] d,
                              input logic act, input logic [7:0] dat);
    vec_t v;
    v = '{rst: r, req: rq, rdy: rd, e_grant: g, e_gid: id, e_done: d, e_act: act, e_data: dat};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'd1;
    return one << i;
  endfunction

  function automatic logic [7:0] beat_of(input logic [31:0] w, input int b);
    logic [31:0] s;
    s = w >> (8 * b);
    return s[7:0];
  endfunction

  // Requester serving word w when both requesters are held high.
  function automatic int exp_id2(input int w);
`ifdef BUS_ARB_BURST_EN
    return (w / 2) % 2;
`else
    return w % 2;
`endif
  endfunction

  initial begin
    int ord [10];
    int w;
    int b;

    words[0] = 32'hA512_3456;
    words[1] = 32'h0BAD_F00D;
    data_in  = {words[1], words[0]};
    rst        = 1'b1;
    req        = 2'b00;
    data_ready = 1'b1;
    rst4        = 1'b1;
    req4        = 4'b0000;
    data_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) data_in4[i*32 +: 32] = 32'h1111_1111 * (i + 1);

    //            rst req  rdy grant id done act data
    vecs[0]  = mk(1, 2'b00, 1, 2'b00, 0, 2'b00, 0, 8'h00);  // reset state
    vecs[1]  = mk(0, 2'b01, 1, 2'b01, 0, 2'b00, 1, 8'h56);  // grant + beat 0 at T+1
    vecs[2]  = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'h34);  // req drop ignored
    vecs[3]  = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'h12);
    vecs[4]  = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'hA5);
    vecs[5]  = mk(0, 2'b00, 1, 2'b00, 0, 2'b01, 0, 8'h00);  // done after last beat
    vecs[6]  = mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 8'h00);
    vecs[7]  = mk(0, 2'b01, 1, 2'b01, 0, 2'b00, 1, 8'h56);  // ready stall on beat 1
    vecs[8]  = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'h34);
    vecs[9]  = mk(0, 2'b00, 0, 2'b01, 0, 2'b00, 1, 8'h34);
    vecs[10] = mk(0, 2'b00, 0, 2'b01, 0, 2'b00, 1, 8'h34);
    vecs[11] = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'h12);
    vecs[12] = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'hA5);
    vecs[13] = mk(0, 2'b00, 1, 2'b00, 0, 2'b01, 0, 8'h00);
    vecs[14] = mk(0, 2'b10, 1, 2'b10, 1, 2'b00, 1, 8'h0D);  // requester 1 word
    vecs[15] = mk(0, 2'b10, 1, 2'b10, 1, 2'b00, 1, 8'hF0);
    vecs[16] = mk(0, 2'b10, 1, 2'b10, 1, 2'b00, 1, 8'hAD);
    vecs[17] = mk(1, 2'b10, 1, 2'b00, 0, 2'b00, 0, 8'h00);  // reset aborts, no done
    vecs[18] = mk(0, 2'b11, 1, 2'b01, 0, 2'b00, 1, 8'h56);  // pointer back to reset value
    vecs[19] = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'h34);
    vecs[20] = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'h12);
    vecs[21] = mk(0, 2'b00, 1, 2'b01, 0, 2'b00, 1, 8'hA5);
    vecs[22] = mk(0, 2'b00, 1, 2'b00, 0, 2'b01, 0, 8'h00);
    vecs[23] = mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 8'h00);

    for (int i = 0; i < NV; i++) begin
      rst        = vecs[i].rst;
      req        = vecs[i].req;
      data_ready = vecs[i].rdy;
      step();
      check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
      check($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
      check($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_act));
      check($sformatf("v%0d data_valid", i), 32'(data_valid), 32'(vecs[i].e_act));
      if (vecs[i].e_act || vecs[i].rst)
        check($sformatf("v%0d data_out", i), 32'(data_out), 32'(vecs[i].e_data));
    end

    // Both requesters held from reset: four back-to-back words.
    rst        = 1'b1;
    req        = 2'b11;
    data_ready = 1'b1;
    step();
    check("hold reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      w = (k - 1) / 4;
      b = (k - 1) % 4;
      check($sformatf("hold k%0d grant_id", k), 32'(grant_id), 32'(exp_id2(w)));
      check($sformatf("hold k%0d grant", k), 32'(grant), 32'(oh(exp_id2(w))));
      check($sformatf("hold k%0d valid", k), 32'(data_valid), 32'd1);
      check($sformatf("hold k%0d data", k), 32'(data_out), 32'(beat_of(words[exp_id2(w)], b)));
      if (b == 0 && w > 0)
        check($sformatf("hold k%0d done", k), 32'(done), 32'(oh(exp_id2(w - 1))));
      else
        check($sformatf("hold k%0d done", k), 32'(done), 32'd0);
    end
    req = 2'b00;
    step();
    check("hold end done", 32'(done), 32'(oh(exp_id2(3))));
    check("hold end valid", 32'(data_valid), 32'd0);
    step();
    check("hold end done clear", 32'(done), 32'd0);

    // Four requesters held; requester 2 drops out after its first done.
    ord = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
    req4 = 4'b1111;
    step();
    rst4 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      w = (k - 1) / 4;
      b = (k - 1) % 4;
      check($sformatf("rr4 k%0d valid", k), 32'(data_valid4), 32'd1);
      if (b == 0) begin
        check($sformatf("rr4 w%0d grant_id", w), 32'(grant_id4), 32'(ord[w]));
        check($sformatf("rr4 w%0d done", w), 32'(done4), (w > 0) ? 32'(oh(ord[w - 1])) : 32'd0);
        if (w == 3) req4[2] = 1'b0;
      end
    end
    req4 = 4'b0000;
    step();
    check("rr4 end done", 32'(done4), 32'(oh(3)));
    check("rr4 end valid", 32'(data_valid4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
